divide_unit: RTL

//  Multi-cycle integer divider for UDIV/SDIV. Accepts two operands read from the register file,

---
 rtl/core_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/divide_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and widths.
// Used by the divider, the WB mux and the register file.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step.
// Shifts in a dividend bit and subtracts the divisor when it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  assign shifted = {rem, dvd_msb};
  assign q_bit   = (shifted >= {1'b0, dvs});

  // When q_bit is set the true difference is below dvs,
  // so the low DATA_W bits hold it exactly.
  assign diff     = shifted[DATA_W-1:0] - dvs;
  assign rem_next = q_bit ? diff : shifted[DATA_W-1:0];

endmodule

// File: rtl/divide_unit.sv
// Multi-cycle UDIV/SDIV unit, one quotient bit per cycle.
// Presents the quotient as a register-file write request.
module divide_unit
  import core_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              flush,
  output logic              busy,
  output logic [ADDR_W-1:0] busy_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] rd_q;
  logic              neg_q;

  logic              accept;
  logic              last;
  logic              div_zero;
  logic              q_bit;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] q_final;
  logic [DATA_W-1:0] dvd_abs;
  logic [DATA_W-1:0] dvs_abs;

  assign in_ready  = (state_q == DIV_IDLE);
  assign busy      = (state_q != DIV_IDLE);
  assign out_valid = (state_q == DIV_DONE);
  assign out_addr  = rd_q;
  assign busy_addr = rd_q;
  assign out_data  = out_data_q;

  assign accept   = in_valid & in_ready & ~flush;
  assign last     = (count_q == CNT_W'(DATA_W - 1));
  assign div_zero = (in_divisor == '0);

  assign dvd_abs = (in_signed & in_dividend[DATA_W-1]) ?
                   -in_dividend : in_dividend;
  assign dvs_abs = (in_signed & in_divisor[DATA_W-1]) ?
                   -in_divisor : in_divisor;

  // dvd_q doubles as the quotient register:
  // dividend bits shift out the top, quotient bits in the bottom.
  assign q_final = {dvd_q[DATA_W-2:0], q_bit};

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[DATA_W-1]),
    .dvs      (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (in_valid) begin
            state_d = div_zero ? DIV_DONE : DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (last) begin
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (out_ready) begin
            state_d = DIV_IDLE;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      out_data_q <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
    end else if (accept) begin
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= dvd_abs;
      dvs_q   <= dvs_abs;
      rd_q    <= in_rd;
      neg_q   <= in_signed &
                 (in_dividend[DATA_W-1] ^ in_divisor[DATA_W-1]);
      if (div_zero) begin
        out_data_q <= '0;
      end
    end else if (state_q == DIV_BUSY && !flush) begin
      count_q <= count_q + 1'b1;
      rem_q   <= rem_next;
      dvd_q   <= q_final;
      if (last) begin
        out_data_q <= neg_q ? -q_final : q_final;
      end
    end
  end

endmodule
